// File: rtl/tpu_pkg.sv
// Shared constants and the feeder state encoding for the TPU image front end.
// Combinational only: no latency, no flow control.
package tpu_pkg;

  localparam int IMG_W     = 32;
  localparam int IMG_H     = 32;
  localparam int PIX_IDX_W = 5;

  // Digit reported when the watchdog aborts a run
  localparam logic [3:0] NO_RESULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_RUN    = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/image_bitmap.sv
// 32x32 binary bitmap: single-pixel write port plus whole-row clear, flat registered output.
// Writes and row clears land at the next edge; no backpressure, the caller gates the enables.
module image_bitmap
  import tpu_pkg::*;
#(
  parameter int NCOLS = IMG_W,
  parameter int NROWS = IMG_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PIX_IDX_W-1:0]   wr_x,
  input  logic [PIX_IDX_W-1:0]   wr_y,
  input  logic                   wr_val,
  input  logic                   clr_en,
  input  logic [PIX_IDX_W-1:0]   clr_row,
  output logic [NCOLS*NROWS-1:0] image
);

  // Packed row-major storage, so the flat bit index is y*NCOLS+x
  logic [NROWS-1:0][NCOLS-1:0] rows_q, rows_d;

  always_comb begin
    rows_d = rows_q;
    if (wr_en) begin
      rows_d[wr_y][wr_x] = wr_val;
    end
    if (clr_en) begin
      rows_d[clr_row] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
    end else begin
      rows_q <= rows_d;
    end
  end

  assign image = rows_q;

endmodule

// File: rtl/tpu_image_feeder.sv
// Bitmap front end that resets/enables the TPU sequencer on start and latches its digit; RUN watchdog under TPU_FEEDER_TIMEOUT_EN.
// Launch is one cycle after start, the result lands at the edge done is sampled; pix_ready is low (writes stalled) outside IDLE.
module tpu_image_feeder #(
  parameter int IMG_W          = tpu_pkg::IMG_W,
  parameter int IMG_H          = tpu_pkg::IMG_H,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           iRst_n,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [tpu_pkg::PIX_IDX_W-1:0]  pix_x,
  input  logic [tpu_pkg::PIX_IDX_W-1:0]  pix_y,
  input  logic                           pix_val,
  input  logic                           clear,
  input  logic                           start,
  output logic                           busy,
  output logic [IMG_W*IMG_H-1:0]         image,
  output logic                           tpu_ena,
  output logic                           tpu_rst_n,
  input  logic                           tpu_done,
  input  logic [3:0]                     tpu_num,
  input  logic                           tpu_overflow,
  output logic [3:0]                     result,
  output logic                           result_overflow,
  output logic                           result_valid,
  output logic                           timeout
);
  import tpu_pkg::*;

  feeder_state_t        state_q, state_d;
  logic [PIX_IDX_W-1:0] clr_row_q, clr_row_d;
  logic [3:0]           result_q, result_d;
  logic                 result_ovf_q, result_ovf_d;
  logic                 result_valid_q, result_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 tpu_ena_q, tpu_ena_d;
  logic                 tpu_rst_n_q, tpu_rst_n_d;
  logic                 bm_wr_en;
  logic                 bm_clr_en;
  logic                 wd_hit;

`ifdef TPU_FEEDER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_LAUNCH) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // wd_cnt_q counts completed RUN cycles, so this fires on the TIMEOUT_CYCLES-th one
  assign wd_hit = (state_q == ST_RUN) && (wd_cnt_q == WD_LAST);
`else
  logic [31:0] timeout_cfg_unused;
  assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    clr_row_d      = clr_row_q;
    result_d       = result_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = result_valid_q;
    timeout_d      = timeout_q;
    bm_wr_en       = 1'b0;
    bm_clr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // clear beats both start and a same-cycle pixel write
        if (clear) begin
          state_d        = ST_CLEAR;
          clr_row_d      = '0;
          result_valid_d = 1'b0;
          timeout_d      = 1'b0;
        end else begin
          bm_wr_en = pix_valid;
          if (start) begin
            state_d        = ST_LAUNCH;
            result_valid_d = 1'b0;
            timeout_d      = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        bm_clr_en = 1'b1;
        clr_row_d = clr_row_q + PIX_IDX_W'(1);
        if (clr_row_q == PIX_IDX_W'(IMG_H - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tpu_done) begin
          result_d       = tpu_num;
          result_ovf_d   = tpu_overflow;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (wd_hit) begin
          result_d       = NO_RESULT;
          result_ovf_d   = 1'b0;
          result_valid_d = 1'b1;
          timeout_d      = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sequencer controls follow the next state so they stay registered yet aligned with it
    tpu_ena_d   = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
    tpu_rst_n_d = (state_d != ST_LAUNCH);
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q        <= ST_IDLE;
      clr_row_q      <= '0;
      result_q       <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      tpu_ena_q      <= 1'b0;
      tpu_rst_n_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      clr_row_q      <= clr_row_d;
      result_q       <= result_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      tpu_ena_q      <= tpu_ena_d;
      tpu_rst_n_q    <= tpu_rst_n_d;
    end
  end

  image_bitmap #(
    .NCOLS (IMG_W),
    .NROWS (IMG_H)
  ) u_bitmap (
    .clk     (clk),
    .rst_n   (iRst_n),
    .wr_en   (bm_wr_en),
    .wr_x    (pix_x),
    .wr_y    (pix_y),
    .wr_val  (pix_val),
    .clr_en  (bm_clr_en),
    .clr_row (clr_row_q),
    .image   (image)
  );

  assign pix_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign tpu_ena         = tpu_ena_q;
  assign tpu_rst_n       = tpu_rst_n_q;
  assign result          = result_q;
  assign result_overflow = result_ovf_q;
  assign result_valid    = result_valid_q;
  assign timeout         = timeout_q;

endmodule
